// File: rtl/core_pkg.sv
// core_pkg: shared types for the integer write-back path.
//   XLEN      - integer data width
//   REG_ZERO  - architectural x0; writes to it are dropped
//   wb_req_t  - one completed result {rd, data}
//   wb_src_e  - producer identity, used for round-robin bookkeeping
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: producer handshakes, register-file write port and
// decode-stage hazard query of the write-back unit.
//   alu_*/lsu_*          - valid/ready result channels from ALU and LSU
//   reg_we/writeaddr/... - registered register-file write port
//   rs1/rs2, hazard1/2   - source registers and their in-flight flags
//   idle                 - nothing queued and no write pending
interface writeback_unit_if #(
  parameter int XLEN = core_pkg::XLEN
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            reg_we;
  logic [4:0]      writeaddr;
  logic [XLEN-1:0] writedata;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            hazard1;
  logic            hazard2;
  logic            idle;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    input  alu_ready, lsu_ready, reg_we, writeaddr, writedata, hazard1, hazard2, idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    output alu_ready, lsu_ready, reg_we, writeaddr, writedata, hazard1, hazard2, idle
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: small FIFO of write-back requests for one producer.
//   push/push_req - enqueue (caller guarantees !full)
//   pop/head      - dequeue / current oldest entry (caller guarantees !empty)
//   full/empty    - occupancy flags
//   ent_valid/ent_rd - per-slot occupancy and destination, for hazard compare
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_req_t               push_req,
  output logic                  full,
  input  logic                  pop,
  output logic                  empty,
  output wb_req_t               head,
  output logic [DEPTH-1:0]      ent_valid,
  output logic [DEPTH-1:0][4:0] ent_rd
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  wb_req_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] offset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_req;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

  // A slot is live when its distance past the read index is below occupancy.
  always_comb begin
    ent_valid = '0;
    ent_rd    = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = AW'(i) - rd_ptr[AW-1:0];
      ent_valid[i] = ({1'b0, offset} < count);
      ent_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and LSU results into one register-file write
// per cycle and flags read-after-write hazards for decode.
//   clk   - core clock
//   reset - asynchronous active-low reset
//   bus   - producer channels, register-file write port, hazard query
module writeback_unit
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              reset,
  writeback_unit_if.slave  bus
);
  logic                  alu_full, alu_empty, alu_push, alu_pop;
  logic                  lsu_full, lsu_empty, lsu_push, lsu_pop;
  wb_req_t               alu_head, lsu_head, pop_req;
  logic [DEPTH-1:0]      alu_ent_valid, lsu_ent_valid;
  logic [DEPTH-1:0][4:0] alu_ent_rd, lsu_ent_rd;
  wb_src_e               last_grant;
  logic                  hit1, hit2;

  // Ready is forced low during reset so nothing is accepted then.
  assign bus.alu_ready = reset && !alu_full;
  assign bus.lsu_ready = reset && !lsu_full;
  assign alu_push      = bus.alu_valid && bus.alu_ready;
  assign lsu_push      = bus.lsu_valid && bus.lsu_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .reset(reset),
    .push(alu_push), .push_req('{rd: bus.alu_rd, data: bus.alu_data}),
    .full(alu_full), .pop(alu_pop), .empty(alu_empty), .head(alu_head),
    .ent_valid(alu_ent_valid), .ent_rd(alu_ent_rd)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk(clk), .reset(reset),
    .push(lsu_push), .push_req('{rd: bus.lsu_rd, data: bus.lsu_data}),
    .full(lsu_full), .pop(lsu_pop), .empty(lsu_empty), .head(lsu_head),
    .ent_valid(lsu_ent_valid), .ent_rd(lsu_ent_rd)
  );

  // Round-robin: on contention the channel that did not win last goes.
  assign alu_pop = !alu_empty && (lsu_empty || last_grant == WB_LSU);
  assign lsu_pop = !lsu_empty && !alu_pop;
  assign pop_req = alu_pop ? alu_head : lsu_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.reg_we    <= 1'b0;
      bus.writeaddr <= '0;
      bus.writedata <= '0;
      last_grant    <= WB_LSU;
    end else begin
      bus.reg_we <= 1'b0;
      if (alu_pop || lsu_pop) begin
        last_grant <= alu_pop ? WB_ALU : WB_LSU;
        // x0 entries are consumed but never reach the register file.
        if (pop_req.rd != REG_ZERO) begin
          bus.reg_we    <= 1'b1;
          bus.writeaddr <= pop_req.rd;
          bus.writedata <= pop_req.data;
        end
      end
    end
  end

  always_comb begin
    hit1 = bus.reg_we && (bus.writeaddr == bus.rs1);
    hit2 = bus.reg_we && (bus.writeaddr == bus.rs2);
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_ent_valid[i] && alu_ent_rd[i] == bus.rs1) hit1 = 1'b1;
      if (lsu_ent_valid[i] && lsu_ent_rd[i] == bus.rs1) hit1 = 1'b1;
      if (alu_ent_valid[i] && alu_ent_rd[i] == bus.rs2) hit2 = 1'b1;
      if (lsu_ent_valid[i] && lsu_ent_rd[i] == bus.rs2) hit2 = 1'b1;
    end
  end

  assign bus.hazard1 = hit1 && (bus.rs1 != REG_ZERO);
  assign bus.hazard2 = hit2 && (bus.rs2 != REG_ZERO);
  assign bus.idle    = alu_empty && lsu_empty && !bus.reg_we;

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and randomized stimulus for writeback_unit,
// checked every cycle against a queue-based reference model plus a few
// literal expectations.
module tb_writeback_unit;
  import core_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  writeback_unit_if wb_if ();

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(wb_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  wb_req_t     alu_q[$];
  wb_req_t     lsu_q[$];
  bit          m_last_lsu = 1'b1;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          alu_acc = 1'b0;
  bit          lsu_acc = 1'b0;
  logic [4:0]  wlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (alu_q[i]) if (alu_q[i].rd == rs) return 1'b1;
    foreach (lsu_q[i]) if (lsu_q[i].rd == rs) return 1'b1;
    return m_we && (m_addr == rs);
  endfunction

  wb_req_t m_e;
  bit      m_pa, m_pl;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_q.delete();
      lsu_q.delete();
      m_last_lsu = 1'b1;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      alu_acc = 1'b0;
      lsu_acc = 1'b0;
    end else begin
      alu_acc = wb_if.alu_valid && (alu_q.size() < DEPTH);
      lsu_acc = wb_if.lsu_valid && (lsu_q.size() < DEPTH);
      m_pa = (alu_q.size() > 0) && ((lsu_q.size() == 0) || m_last_lsu);
      m_pl = !m_pa && (lsu_q.size() > 0);
      m_we = 1'b0;
      if (m_pa || m_pl) begin
        if (m_pa) begin
          m_e = alu_q.pop_front();
          m_last_lsu = 1'b0;
        end else begin
          m_e = lsu_q.pop_front();
          m_last_lsu = 1'b1;
        end
        if (m_e.rd != 5'd0) begin
          m_we = 1'b1;
          m_addr = m_e.rd;
          m_data = m_e.data;
        end
      end
      if (alu_acc) alu_q.push_back('{rd: wb_if.alu_rd, data: wb_if.alu_data});
      if (lsu_acc) lsu_q.push_back('{rd: wb_if.lsu_rd, data: wb_if.lsu_data});
    end
  end

  // Compare process: inputs change on the falling edge, outputs sampled 2 units later.
  always @(negedge clk) begin
    #2;
    check("alu_ready", wb_if.alu_ready, reset && (alu_q.size() < DEPTH));
    check("lsu_ready", wb_if.lsu_ready, reset && (lsu_q.size() < DEPTH));
    check("reg_we",    wb_if.reg_we,    m_we);
    check("writeaddr", wb_if.writeaddr, m_addr);
    check("writedata", wb_if.writedata, m_data);
    check("hazard1",   wb_if.hazard1,   m_hazard(wb_if.rs1));
    check("hazard2",   wb_if.hazard2,   m_hazard(wb_if.rs2));
    check("idle",      wb_if.idle,      (alu_q.size() == 0) && (lsu_q.size() == 0) && !m_we);
    if (wb_if.reg_we === 1'b1) wlog.push_back(wb_if.writeaddr);
  end

  int a_n, l_n, cyc;
  logic [4:0] exp_addr;

  initial begin
    wb_if.alu_valid = 0; wb_if.alu_rd = 0; wb_if.alu_data = 0;
    wb_if.lsu_valid = 0; wb_if.lsu_rd = 0; wb_if.lsu_data = 0;
    wb_if.rs1 = 0; wb_if.rs2 = 0;

    repeat (3) @(negedge clk);
    #3;
    check("rst_alu_ready_lit", wb_if.alu_ready, 1'b0);
    check("rst_reg_we_lit", wb_if.reg_we, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #3;
    check("post_rst_idle_lit", wb_if.idle, 1'b1);

    // Single ALU write rd=5
    @(negedge clk);
    wb_if.alu_valid = 1; wb_if.alu_rd = 5'd5; wb_if.alu_data = 32'hDEADBEEF; wb_if.rs1 = 5'd5;
    #3 check("single_haz_before_lit", wb_if.hazard1, 1'b0);
    @(negedge clk);
    wb_if.alu_valid = 0;
    #3 check("single_haz_fifo_lit", wb_if.hazard1, 1'b1);
    check("single_we_early_lit", wb_if.reg_we, 1'b0);
    @(negedge clk);
    #3 check("single_we_lit", wb_if.reg_we, 1'b1);
    check("single_addr_lit", wb_if.writeaddr, 32'd5);
    check("single_data_lit", wb_if.writedata, 32'hDEADBEEF);
    check("single_haz_we_lit", wb_if.hazard1, 1'b1);
    @(negedge clk);
    #3 check("single_we_off_lit", wb_if.reg_we, 1'b0);
    check("single_haz_off_lit", wb_if.hazard1, 1'b0);
    check("single_idle_lit", wb_if.idle, 1'b1);

    // LSU x0 write dropped, following rd=3 written
    @(negedge clk);
    wb_if.lsu_valid = 1; wb_if.lsu_rd = 5'd0; wb_if.lsu_data = 32'h1234; wb_if.rs1 = 5'd0;
    @(negedge clk);
    wb_if.lsu_rd = 5'd3; wb_if.lsu_data = 32'h55;
    #3 check("x0_haz_lit", wb_if.hazard1, 1'b0);
    @(negedge clk);
    wb_if.lsu_valid = 0;
    #3 check("x0_we_lit", wb_if.reg_we, 1'b0);
    check("x0_addr_hold_lit", wb_if.writeaddr, 32'd5);
    @(negedge clk);
    #3 check("x3_we_lit", wb_if.reg_we, 1'b1);
    check("x3_addr_lit", wb_if.writeaddr, 32'd3);
    check("x3_data_lit", wb_if.writedata, 32'h55);

    // Both channels saturating: ALU rd 1..8, LSU rd 9..16
    @(negedge clk);
    wlog.delete();
    a_n = 0; l_n = 0; cyc = 0;
    while ((a_n < 8 || l_n < 8 || alu_q.size() > 0 || lsu_q.size() > 0 || m_we) && cyc < 80) begin
      if (cyc > 0) begin
        if (alu_acc) a_n++;
        if (lsu_acc) l_n++;
      end
      wb_if.alu_valid = (a_n < 8);
      wb_if.alu_rd    = 5'(1 + a_n);
      wb_if.alu_data  = 32'hA000_0000 + 32'(a_n);
      wb_if.lsu_valid = (l_n < 8);
      wb_if.lsu_rd    = 5'(9 + l_n);
      wb_if.lsu_data  = 32'hB000_0000 + 32'(l_n);
      wb_if.rs1 = 5'(cyc % 17);
      wb_if.rs2 = 5'((cyc + 9) % 17);
      cyc++;
      @(negedge clk);
    end
    check("sat_timeout", (cyc < 80), 1'b1);
    wb_if.alu_valid = 0; wb_if.lsu_valid = 0;
    repeat (2) @(negedge clk);
    #3 check("sat_count", wlog.size(), 32'd16);
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      exp_addr = (i % 2 == 0) ? 5'(1 + i / 2) : 5'(9 + i / 2);
      check("sat_order", wlog[i], exp_addr);
    end

    // Reset while both FIFOs hold entries
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wb_if.alu_valid = 1; wb_if.alu_rd = 5'(20 + i); wb_if.alu_data = 32'(i);
      wb_if.lsu_valid = 1; wb_if.lsu_rd = 5'(24 + i); wb_if.lsu_data = 32'(i + 100);
      @(negedge clk);
    end
    wb_if.alu_valid = 0; wb_if.lsu_valid = 0;
    reset = 1'b0;
    #3 check("midrst_we_lit", wb_if.reg_we, 1'b0);
    check("midrst_ready_lit", wb_if.lsu_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #3 check("rel_alu_ready_lit", wb_if.alu_ready, 1'b1);
    check("rel_lsu_ready_lit", wb_if.lsu_ready, 1'b1);
    check("rel_idle_lit", wb_if.idle, 1'b1);
    wlog.delete();
    repeat (4) @(negedge clk);
    #3 check("rel_no_stale", wlog.size(), 32'd0);

    // Randomized traffic
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      if (!wb_if.alu_valid || alu_acc || $urandom_range(0, 3) == 0) begin
        wb_if.alu_valid = ($urandom_range(0, 2) != 0);
        wb_if.alu_rd    = 5'($urandom_range(0, 7));
        wb_if.alu_data  = $urandom;
      end
      if (!wb_if.lsu_valid || lsu_acc || $urandom_range(0, 3) == 0) begin
        wb_if.lsu_valid = ($urandom_range(0, 2) != 0);
        wb_if.lsu_rd    = 5'($urandom_range(0, 7));
        wb_if.lsu_data  = $urandom;
      end
      wb_if.rs1 = 5'($urandom_range(0, 7));
      wb_if.rs2 = 5'($urandom_range(0, 7));
      @(negedge clk);
    end
    wb_if.alu_valid = 0; wb_if.lsu_valid = 0;
    repeat (8) @(negedge clk);
    #3 check("final_idle_lit", wb_if.idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
